mem_arbiter: RTL and testbench

- Shares the single main-memory line port between icache refills (read-only) and dcache refills/writebacks (read/write).
- Sits between icache, dcache and the memory model in the core.
- Issues one line transaction at a time and returns one-cycle ack pulses to the winning requester.
- Uses round-robin arbitration on contention.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter between icache and dcache.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 128;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {REQ_IC, REQ_DC} req_id_t;

  // Round-robin pick: a tie goes to whoever did not win last time.
  function automatic req_id_t rr_pick(input logic ic_req, input logic dc_req, input req_id_t last);
    if (ic_req && dc_req) begin
      return (last == REQ_IC) ? REQ_DC : REQ_IC;
    end else if (ic_req) begin
      return REQ_IC;
    end
    return REQ_DC;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one main-memory line port between icache refills and dcache refills/writebacks.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_ack_o,
  output logic [LINE_W-1:0] ic_rdata_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_ack_o,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_rdata_i
);

  state_t  state, state_d;
  req_id_t last_gnt, gnt_id;
  req_id_t pick_c;
  logic    grant_c;
  logic    done_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    grant_c = 1'b0;
    done_c  = 1'b0;
    pick_c  = rr_pick(ic_req_i, dc_req_i, last_gnt);
    case (state)
      IDLE: begin
        if (ic_req_i || dc_req_i) begin
          grant_c = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          done_c  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs double as the latched transaction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt    <= REQ_DC;
      gnt_id      <= REQ_IC;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      ic_ack_o    <= 1'b0;
      dc_ack_o    <= 1'b0;
      ic_rdata_o  <= '0;
      dc_rdata_o  <= '0;
    end else begin
      ic_ack_o <= 1'b0;
      dc_ack_o <= 1'b0;
      if (grant_c) begin
        gnt_id    <= pick_c;
        last_gnt  <= pick_c;
        mem_req_o <= 1'b1;
        if (pick_c == REQ_DC) begin
          mem_we_o    <= dc_we_i;
          mem_addr_o  <= dc_addr_i;
          mem_wdata_o <= dc_wdata_i;
        end else begin
          mem_we_o   <= 1'b0;
          mem_addr_o <= ic_addr_i;
        end
      end
      // Ack pulse and data land together so they are valid during RESP.
      if (done_c) begin
        mem_req_o <= 1'b0;
        if (gnt_id == REQ_IC) begin
          ic_ack_o   <= 1'b1;
          ic_rdata_o <= mem_rdata_i;
        end else begin
          dc_ack_o   <= 1'b1;
          dc_rdata_o <= mem_rdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of solo transactions plus contention/reset sequences.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;

  logic          clk, rst;
  logic          ic_req_i, ic_ack_o;
  logic [AW-1:0] ic_addr_i;
  logic [LW-1:0] ic_rdata_o;
  logic          dc_req_i, dc_we_i, dc_ack_o;
  logic [AW-1:0] dc_addr_i;
  logic [LW-1:0] dc_wdata_i, dc_rdata_o;
  logic          mem_req_o, mem_we_o, mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_wdata_o, mem_rdata_i;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_ack_o(ic_ack_o), .ic_rdata_o(ic_rdata_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_ack_o(dc_ack_o), .dc_rdata_o(dc_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          is_dc;
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            lat;
    logic [LW-1:0] rdata;
    logic          exp_we;
    int            exp_cyc;
  } vec_t;

  vec_t tbl [6];
  int ntests = 0;
  int nfail  = 0;
  int lat    = 0;
  int mcnt   = 0;
  logic [LW-1:0] mem_data;

  // Contention bookkeeping
  req_id_t       ord [$];
  int            ack_at [$];
  logic          we_at [$];
  logic [AW-1:0] addr_at [$];
  logic [LW-1:0] wd_at [$];
  int            unstable;
  logic [LW-1:0] last_ic_rd;
  logic [AW-1:0] c_ic_addr, c_dc_addr;
  logic [LW-1:0] c_dc_wdata;
  logic          c_dc_we;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic outs_nz();
    return |{ic_ack_o, ic_rdata_o, dc_ack_o, dc_rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o};
  endfunction

  // One clock; then the memory model reacts to what it sees this cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      mem_ack_i = 1'b0;
      mcnt      = 0;
    end else if (mem_req_o) begin
      if (mcnt == lat) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_data;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = ~mem_data;
      end
      mcnt++;
    end else begin
      mem_ack_i = 1'b0;
      mcnt      = 0;
    end
  endtask

  task automatic contend(input int n_ic, input int n_dc, input int lat_in);
    int  ic_rem, dc_rem, t;
    logic prev_req;
    ord.delete(); ack_at.delete(); we_at.delete(); addr_at.delete(); wd_at.delete();
    unstable = 0;
    lat = lat_in;
    ic_rem = n_ic; dc_rem = n_dc;
    ic_addr_i = c_ic_addr; dc_addr_i = c_dc_addr; dc_we_i = c_dc_we; dc_wdata_i = c_dc_wdata;
    ic_req_i = (ic_rem > 0); dc_req_i = (dc_rem > 0);
    prev_req = mem_req_o;
    t = 0;
    while ((ic_rem > 0 || dc_rem > 0) && t < 200) begin
      step(); t++;
      if (mem_req_o && !prev_req) begin
        we_at.push_back(mem_we_o); addr_at.push_back(mem_addr_o); wd_at.push_back(mem_wdata_o);
      end else if (mem_req_o) begin
        if (mem_we_o !== we_at[$] || mem_addr_o !== addr_at[$] || mem_wdata_o !== wd_at[$]) unstable++;
      end
      prev_req = mem_req_o;
      if (ic_ack_o) begin
        ord.push_back(REQ_IC); ack_at.push_back(t); last_ic_rd = ic_rdata_o;
        ic_rem--; if (ic_rem <= 0) ic_req_i = 1'b0;
      end
      if (dc_ack_o) begin
        ord.push_back(REQ_DC); ack_at.push_back(t);
        dc_rem--; if (dc_rem <= 0) dc_req_i = 1'b0;
      end
    end
    ic_req_i = 1'b0; dc_req_i = 1'b0;
    chk("contend_done", LW'(ic_rem + dc_rem), '0);
    step();
  endtask

  initial begin
    int nz, t, busy, bad, other, ack_t, dacks;
    logic got;
    logic [LW-1:0] rd;
    vec_t v;

    rst = 1'b1;
    ic_req_i = 0; ic_addr_i = '0; dc_req_i = 0; dc_we_i = 0; dc_addr_i = '0; dc_wdata_i = '0;
    mem_ack_i = 0; mem_rdata_i = '0; mem_data = '0;

    tbl[0] = '{1'b0, 1'b1, 32'h0000_0040, {16{8'h11}}, 3, {96'hDEADBEEF_DEADBEEF_DEADBEEF, 32'hDEADBE01}, 1'b0, 5};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0200, {16{8'h22}}, 0, {4{32'h1234_5678}}, 1'b0, 2};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0300, {16{8'h5A}}, 1, {4{32'hCAFE_F00D}}, 1'b1, 3};
    tbl[3] = '{1'b0, 1'b0, 32'h0000_1000, {16{8'h33}}, 0, {4{32'h0BAD_C0DE}}, 1'b0, 2};
    tbl[4] = '{1'b1, 1'b1, 32'hFFFF_FFC0, {16{8'hC3}}, 2, {4{32'h8765_4321}}, 1'b1, 4};
    tbl[5] = '{1'b0, 1'b0, 32'hFFFF_FFF0, {16{8'h44}}, 4, {4{32'hFEED_FACE}}, 1'b0, 6};

    // Reset state, then ten idle cycles with no requests
    step(); step();
    chk("reset_outs", LW'(outs_nz()), '0);
    rst = 1'b0;
    nz = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (outs_nz()) nz++;
    end
    chk("idle_outs_10cyc", LW'(nz), '0);

    // Simultaneous first requests: icache wins the first tie
    c_ic_addr = 32'h0000_0040; c_dc_addr = 32'h0000_0100; c_dc_we = 1'b1; c_dc_wdata = {16{8'hA5}};
    mem_data = {4{32'h0101_0101}};
    contend(1, 1, 1);
    chk("pair_count", LW'(ord.size()), LW'(2));
    if (ord.size() == 2 && we_at.size() == 2) begin
      chk("pair_first_ic", LW'(ord[0]), LW'(REQ_IC));
      chk("pair_second_dc", LW'(ord[1]), LW'(REQ_DC));
      chk("pair_ic_we", LW'(we_at[0]), '0);
      chk("pair_ic_addr", LW'(addr_at[0]), LW'(32'h40));
      chk("pair_dc_we", LW'(we_at[1]), LW'(1));
      chk("pair_dc_addr", LW'(addr_at[1]), LW'(32'h100));
      chk("pair_dc_wdata", wd_at[1], {16{8'hA5}});
      chk("pair_ic_rdata", last_ic_rd, {4{32'h0101_0101}});
    end
    chk("pair_unstable", LW'(unstable), '0);

    // Continuous contention, zero-wait memory
    c_ic_addr = 32'h0000_0080; c_dc_addr = 32'h0000_0180; c_dc_we = 1'b1; c_dc_wdata = {16{8'h96}};
    contend(3, 3, 0);
    chk("rr_count", LW'(ord.size()), LW'(6));
    for (int k = 0; k < ord.size() && k < 6; k++)
      chk($sformatf("rr_order_%0d", k), LW'(ord[k]), (k % 2 == 1) ? LW'(REQ_DC) : LW'(REQ_IC));
    for (int k = 1; k < ack_at.size(); k++)
      chk($sformatf("rr_spacing_%0d", k), LW'(ack_at[k] - ack_at[k-1]), LW'(3));
    chk("rr_unstable", LW'(unstable), '0);

    // Solo transactions from the vector table
    foreach (tbl[r]) begin
      v = tbl[r];
      lat = v.lat; mem_data = v.rdata;
      dc_we_i = v.we; dc_wdata_i = v.wdata;
      if (v.is_dc) begin
        dc_addr_i = v.addr; ic_addr_i = ~v.addr; dc_req_i = 1'b1;
      end else begin
        ic_addr_i = v.addr; dc_addr_i = ~v.addr; ic_req_i = 1'b1;
      end
      t = 0; got = 0; busy = 0; bad = 0; other = 0; ack_t = -1; rd = '0;
      while (!got && t < 40) begin
        step(); t++;
        if (mem_req_o) begin
          busy++;
          if (mem_addr_o !== v.addr || mem_we_o !== v.exp_we || (v.exp_we && mem_wdata_o !== v.wdata)) bad++;
          // Changes after grant must be ignored
          dc_we_i = ~v.we; dc_wdata_i = ~v.wdata;
        end
        if (v.is_dc ? ic_ack_o : dc_ack_o) other++;
        if (v.is_dc ? dc_ack_o : ic_ack_o) begin
          got = 1'b1; ack_t = t;
          rd = v.is_dc ? dc_rdata_o : ic_rdata_o;
          ic_req_i = 1'b0; dc_req_i = 1'b0;
        end
      end
      ic_req_i = 1'b0; dc_req_i = 1'b0;
      chk($sformatf("v%0d_ack_seen", r), LW'(got), LW'(1));
      chk($sformatf("v%0d_latency", r), LW'(ack_t), LW'(v.exp_cyc));
      chk($sformatf("v%0d_busy_cycles", r), LW'(busy), LW'(v.lat + 1));
      chk($sformatf("v%0d_mem_fields", r), LW'(bad), '0);
      chk($sformatf("v%0d_other_ack", r), LW'(other), '0);
      if (!v.exp_we) chk($sformatf("v%0d_rdata", r), rd, v.rdata);
      step();
      chk($sformatf("v%0d_ack_one_pulse", r), LW'({ic_ack_o, dc_ack_o}), '0);
    end

    // Reset in the middle of a dcache write
    lat = 5; mem_data = {4{32'h7777_7777}};
    dc_addr_i = 32'h0000_0400; dc_we_i = 1'b1; dc_wdata_i = {16{8'h3C}}; dc_req_i = 1'b1;
    t = 0;
    while (!mem_req_o && t < 10) begin step(); t++; end
    chk("midbusy_started", LW'(mem_req_o), LW'(1));
    step();
    #2 rst = 1'b1;
    #1 chk("async_reset_outs", LW'(outs_nz()), '0);
    dc_req_i = 1'b0;
    step();
    rst = 1'b0;
    dacks = 0; nz = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (dc_ack_o) dacks++;
      if (mem_req_o) nz++;
    end
    chk("abort_no_dc_ack", LW'(dacks), '0);
    chk("abort_mem_idle", LW'(nz), '0);

    c_ic_addr = 32'h0000_0500; c_dc_addr = 32'h0000_0600; c_dc_we = 1'b0; c_dc_wdata = '0;
    mem_data = {4{32'h2468_ACE0}};
    contend(1, 1, 1);
    chk("post_reset_count", LW'(ord.size()), LW'(2));
    if (ord.size() >= 1) chk("post_reset_ic_first", LW'(ord[0]), LW'(REQ_IC));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
